// File: rtl/axi_lite_regbank_pkg.sv
// Shared types and sizing helpers for the AXI4-Lite register bank.
package axi_lite_regbank_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    // Byte-offset bits dropped from an address to form a word index.
    function automatic int unsigned addr_lsb(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int unsigned idx_w(input int unsigned num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/axi_lite_regbank_decode.sv
// Combinational address decoder: word index, range check and read-only lookup.
module axi_lite_regbank_decode
    import axi_lite_regbank_pkg::*;
#(
    parameter int unsigned             C_DATA_WIDTH = 32,
    parameter int unsigned             C_ADDR_WIDTH = 32,
    parameter int unsigned             C_NUM_REGS   = 32,
    parameter logic [C_NUM_REGS-1:0]   C_RO_MASK    = '0
) (
    input  logic [C_ADDR_WIDTH-1:0]          addr,
    output logic [idx_w(C_NUM_REGS)-1:0]     index,
    output logic                             in_range,
    output logic                             is_ro
);

    localparam int unsigned ADDR_LSB = addr_lsb(C_DATA_WIDTH);
    localparam int unsigned IDX_W    = idx_w(C_NUM_REGS);

    logic [C_ADDR_WIDTH-1:0] word;
    logic                    unused_low;

    // Range check uses the full word address so aliases above the bank fault.
    assign word       = addr >> ADDR_LSB;
    assign index      = word[IDX_W-1:0];
    assign in_range   = 64'(word) < 64'(C_NUM_REGS);
    assign is_ro      = in_range && C_RO_MASK[index];
    assign unused_low = ^addr[ADDR_LSB-1:0];

endmodule

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank with byte strobes, read-only hardware slots,
// decode-error responses and per-register access pulses.
module axi_lite_regbank
    import axi_lite_regbank_pkg::*;
#(
    parameter int unsigned               C_DATA_WIDTH = 32,
    parameter int unsigned               C_ADDR_WIDTH = 32,
    parameter int unsigned               C_NUM_REGS   = 32,
    parameter logic [C_NUM_REGS-1:0]     C_RO_MASK    = '0,
    parameter logic [C_DATA_WIDTH-1:0]   C_RESET_VAL  = '0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [C_ADDR_WIDTH-1:0]              awaddr,
    input  logic [2:0]                           awprot,
    input  logic                                 awvalid,
    output logic                                 awready,
    input  logic [C_DATA_WIDTH-1:0]              wdata,
    input  logic [C_DATA_WIDTH/8-1:0]            wstrb,
    input  logic                                 wvalid,
    output logic                                 wready,
    output logic [1:0]                           bresp,
    output logic                                 bvalid,
    input  logic                                 bready,
    input  logic [C_ADDR_WIDTH-1:0]              araddr,
    input  logic [2:0]                           arprot,
    input  logic                                 arvalid,
    output logic                                 arready,
    output logic [C_DATA_WIDTH-1:0]              rdata,
    output logic [1:0]                           rresp,
    output logic                                 rvalid,
    input  logic                                 rready,
    output logic [C_NUM_REGS*C_DATA_WIDTH-1:0]   reg_q,
    input  logic [C_NUM_REGS*C_DATA_WIDTH-1:0]   reg_d,
    output logic [C_NUM_REGS-1:0]                reg_wr_pulse,
    output logic [C_NUM_REGS-1:0]                reg_rd_pulse
);

    localparam int unsigned DW     = C_DATA_WIDTH;
    localparam int unsigned STRB_W = C_DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = idx_w(C_NUM_REGS);

    logic                            aw_held;
    logic                            w_held;
    logic [C_ADDR_WIDTH-1:0]         aw_addr;
    logic [DW-1:0]                   w_data;
    logic [STRB_W-1:0]               w_strb;
    logic [C_NUM_REGS-1:0][DW-1:0]   regs;
    logic [C_NUM_REGS-1:0][DW-1:0]   hw_d;

    logic [IDX_W-1:0]                wr_idx;
    logic [IDX_W-1:0]                rd_idx;
    logic                            wr_in_range;
    logic                            wr_is_ro;
    logic                            rd_in_range;
    logic                            rd_is_ro;

    logic                            aw_hs;
    logic                            w_hs;
    logic                            ar_hs;
    logic                            commit;
    logic                            wr_ok;
    logic                            unused_prot;

    assign awready     = !rst && !aw_held && !bvalid;
    assign wready      = !rst && !w_held && !bvalid;
    assign arready     = !rst && !rvalid;
    assign aw_hs       = awvalid && awready;
    assign w_hs        = wvalid && wready;
    assign ar_hs       = arvalid && arready;
    assign commit      = aw_held && w_held;
    assign wr_ok       = wr_in_range && !wr_is_ro;
    assign hw_d        = reg_d;
    assign unused_prot = ^{awprot, arprot};

    // Write path decodes the held address; read path decodes araddr live.
    axi_lite_regbank_decode #(
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .C_ADDR_WIDTH (C_ADDR_WIDTH),
        .C_NUM_REGS   (C_NUM_REGS),
        .C_RO_MASK    (C_RO_MASK)
    ) u_wr_decode (
        .addr     (aw_addr),
        .index    (wr_idx),
        .in_range (wr_in_range),
        .is_ro    (wr_is_ro)
    );

    axi_lite_regbank_decode #(
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .C_ADDR_WIDTH (C_ADDR_WIDTH),
        .C_NUM_REGS   (C_NUM_REGS),
        .C_RO_MASK    (C_RO_MASK)
    ) u_rd_decode (
        .addr     (araddr),
        .index    (rd_idx),
        .in_range (rd_in_range),
        .is_ro    (rd_is_ro)
    );

    // AW and W holding slots; filled independently, emptied together on commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
        end else if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_addr <= awaddr;
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= wdata;
                w_strb <= wstrb;
            end
        end
    end

    // B channel and write pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            bvalid       <= 1'b0;
            bresp        <= OKAY;
            reg_wr_pulse <= '0;
        end else begin
            reg_wr_pulse <= '0;
            if (commit) begin
                bvalid <= 1'b1;
                bresp  <= wr_ok ? OKAY : SLVERR;
                if (wr_ok) begin
                    reg_wr_pulse <= C_NUM_REGS'(1) << wr_idx;
                end
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Register array; only enabled byte lanes of RW registers change.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= {C_NUM_REGS{C_RESET_VAL}};
        end else if (commit && wr_ok) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (w_strb[b]) begin
                    regs[wr_idx][b*8 +: 8] <= w_data[b*8 +: 8];
                end
            end
        end
    end

    // R channel and read pulse; a same-edge commit is not visible here.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid       <= 1'b0;
            rdata        <= '0;
            rresp        <= OKAY;
            reg_rd_pulse <= '0;
        end else begin
            reg_rd_pulse <= '0;
            if (ar_hs) begin
                rvalid <= 1'b1;
                if (!rd_in_range) begin
                    rdata <= '0;
                    rresp <= SLVERR;
                end else begin
                    rdata        <= rd_is_ro ? hw_d[rd_idx] : regs[rd_idx];
                    rresp        <= OKAY;
                    reg_rd_pulse <= C_NUM_REGS'(1) << rd_idx;
                end
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_reg_q
        assign reg_q[i*DW +: DW] = C_RO_MASK[i] ? '0 : regs[i];
    end

endmodule

// File: doc/axi_lite_regbank.md
# axi_lite_regbank

Parametrised AXI4-Lite slave register bank, the successor to `axi_lite_template`. It exposes C_NUM_REGS word registers to fabric logic and adds:
- byte-strobe writes;
- per-register read-only mapping from hardware inputs;
- SLVERR on decode faults;
- independent AW/W acceptance;
- per-register write and read pulses.

It sits between the system AXI4-Lite interconnect and a peripheral's control/status logic.

## Interface
- C_DATA_WIDTH, 32: data bus width; 32 or 64.
- C_ADDR_WIDTH, 32: address bus width.
- C_NUM_REGS, 32: register count, 1..256.
- C_RO_MASK, all 0 (C_NUM_REGS bits): bit i set means register i is read-only and is sourced from reg_d.
- C_RESET_VAL, 0: reset value of every RW register.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- awaddr in C_ADDR_WIDTH; awprot in 3 (ignored); awvalid in 1; awready out 1.
- wdata in C_DATA_WIDTH; wstrb in C_DATA_WIDTH/8; wvalid in 1; wready out 1.
- bresp out 2; bvalid out 1; bready in 1.
- araddr in C_ADDR_WIDTH; arprot in 3 (ignored); arvalid in 1; arready out 1.
- rdata out C_DATA_WIDTH; rresp out 2; rvalid out 1; rready in 1.
- reg_q  out  C_NUM_REGS*C_DATA_WIDTH  RW register contents; register i at [i*C_DATA_WIDTH +: C_DATA_WIDTH]. RO slots drive 0.
- reg_d  in  C_NUM_REGS*C_DATA_WIDTH  hardware values for RO registers; same packing.
- reg_wr_pulse  out  C_NUM_REGS  one-cycle strobe per successful write.
- reg_rd_pulse  out  C_NUM_REGS  one-cycle strobe per successful read (for clear-on-read logic).

## Operation
- Decode: ADDR_LSB = log2(C_DATA_WIDTH/8); index = addr >> ADDR_LSB.
  - Address bits below ADDR_LSB are ignored.
  - index >= C_NUM_REGS is a decode error.
- Write path: holding slots for AW and W.
  - awready = !rst && !aw_held && !bvalid; wready = !rst && !w_held && !bvalid.
  - AW and W may handshake in either order, or in the same cycle.
  - Once both are held, the commit edge does all of the following:
    - updates RW register bytes where wstrb=1; bytes with wstrb=0 are unchanged;
    - clears both slots;
    - sets bvalid.
  - Decode error, or write to a RO register: no update, bresp=SLVERR (2'b10). Otherwise OKAY (2'b00).
  - bvalid holds with stable bresp until bready.
- Read path: arready = !rst && !rvalid.
  - On AR handshake, the next edge sets rvalid and latches rdata/rresp.
  - rdata source: RW → reg_q slot; RO → reg_d sampled at the AR handshake edge; decode error → 0 with SLVERR.
  - rdata and rresp are stable until rready.
- Pulses:
  - reg_wr_pulse[i] is high for exactly the cycle after the commit edge of an OKAY write to i (the first bvalid cycle).
  - reg_rd_pulse[i] is high in the first rvalid cycle of an OKAY read of i.
- Read and write paths are fully independent. A read handshaking on the same edge as a write commit to the same register returns the pre-write value.

## Timing
- Reset values:
  - awready, wready, arready, bvalid, rvalid, all pulses: 0.
  - bresp, rresp, rdata: 0.
  - RW registers: C_RESET_VAL.
- Readies go to 1 in the first cycle with rst low.
- Write latency: bvalid rises 1 cycle after the later of the AW/W handshakes.
- Readies reassert the cycle after the B handshake. Sustained throughput is one write per 3 cycles with bready tied high.
- Read latency: rvalid 1 cycle after AR handshake. Throughput is one read per 2 cycles with rready tied high.
- Backpressure: a second AW while aw_held is not accepted (awready=0); the same rule applies to W.
- rst mid-transaction:
  - held AW/W are discarded, with no register update;
  - bvalid and rvalid drop at the reset edge;
  - the master must reissue the transaction.

## Structure
- Package `axi_lite_regbank_pkg`:
  - resp_t enum (OKAY=2'b00, SLVERR=2'b10);
  - functions clog2-based ADDR_LSB and IDX_W.
- Sub-module `axi_lite_regbank_decode`, instantiated twice (write and read paths):
  - inputs: address;
  - outputs: index, in_range, is_ro from C_RO_MASK;
  - purely combinational.
- The top level holds the write slots, the B/R channel registers and the register array.

## Test plan
- Reset: with rst=1, all readies, valids and pulses are 0.
  - After release, reading register 5 returns C_RESET_VAL with OKAY.
- Strobes: write 0xAABBCCDD to addr 0x10 (strb 1111), then 0x11223344 (strb 0101).
  - Read of 0x10 returns 0xAA22CC44.
  - reg_wr_pulse[4] is high for exactly 1 cycle per write.
- Ordering: W presented 3 cycles before AW at addr 0x08.
  - bvalid rises 1 cycle after the AW handshake.
  - Repeat with AW first, and with both in the same cycle; register 2 is correct each time.
- Errors: C_NUM_REGS=8.
  - Write to 0x20 → SLVERR, no reg_q change, no pulse.
  - Read of 0x20 → rdata 0, SLVERR.
- RO: C_RO_MASK bit 3 set, reg_d slot 3 = 0xDEADBEEF.
  - Read 0x0C → 0xDEADBEEF OKAY, reg_rd_pulse[3] high 1 cycle.
  - Write 0x0C → SLVERR.
- Backpressure/reset: hold bready=0 for 5 cycles; awready/wready stay 0 and bresp stays stable.
  - Asserting rst while AW is held (W pending) leaves the target register at C_RESET_VAL and produces no B response.
